// File: rtl/layer0_feeder_pkg.sv
// Shared constants for the layer0 feeder: token width default, rail levels, FSM encodings.
package layer0_feeder_pkg;

  localparam int BIT_INL0 = 8;

  localparam logic ON  = 1'b1;
  localparam logic OFF = 1'b0;

  localparam logic [1:0] FEED_IDLE   = 2'd0;
  localparam logic [1:0] FEED_DATA   = 2'd1;
  localparam logic [1:0] FEED_SPACER = 2'd2;

  // Counter width that still works for degenerate lengths of 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/layer0_feeder_sync_fifo.sv
// Power-of-two FIFO with registered occupancy; head is the oldest entry, valid when !empty.
// Full/empty derive from the count register, so a pop never frees a slot in the same cycle.
module layer0_feeder_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= data;
  end

endmodule

// File: rtl/layer0_feeder.sv
// Clocked valid/ready to four-phase dual-rail bridge; word appears two edges after presentation, in_ready = !full.
// LAYER0_FEEDER_ACK_SYNC_EN adds a two-flop ack synchronizer (ack to rail change = 3 edges, else 1).
module layer0_feeder
  import layer0_feeder_pkg::*;
#(
  parameter int WIDTH     = BIT_INL0,
  parameter int DEPTH     = 4,
  parameter int FRAME_LEN = 784
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             ack,
  output logic [WIDTH-1:0] xt,
  output logic [WIDTH-1:0] xf,
  output logic             frame_done
);

  localparam int CW = cnt_width(FRAME_LEN);
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

  logic             fifo_full;
  logic             fifo_empty;
  logic [WIDTH-1:0] head;
  logic             push;
  logic             pop;
  logic             ack_s;
  logic [1:0]       state;
  logic [CW-1:0]    frame_cnt;

  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;
  assign pop      = (state == FEED_DATA) && ack_s;

`ifdef LAYER0_FEEDER_ACK_SYNC_EN
  logic ack_q1;
  logic ack_q2;

  always_ff @(posedge clock) begin
    if (!reset) begin
      ack_q1 <= 1'b0;
      ack_q2 <= 1'b0;
    end else begin
      ack_q1 <= ack;
      ack_q2 <= ack_q1;
    end
  end

  assign ack_s = ack_q2;
`else
  assign ack_s = ack;
`endif

  layer0_feeder_sync_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock(clock),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .data (in_data),
    .full (fifo_full),
    .empty(fifo_empty),
    .head (head)
  );

  // Rails only change on entry to DATA (new codeword) or on leaving it (spacer).
  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= FEED_IDLE;
      xt         <= {WIDTH{OFF}};
      xf         <= {WIDTH{OFF}};
      frame_done <= OFF;
      frame_cnt  <= '0;
    end else begin
      frame_done <= OFF;
      case (state)
        FEED_IDLE: begin
          if (!fifo_empty && !ack_s) begin
            xt    <= head;
            xf    <= ~head;
            state <= FEED_DATA;
          end
        end
        FEED_DATA: begin
          if (ack_s) begin
            xt    <= {WIDTH{OFF}};
            xf    <= {WIDTH{OFF}};
            state <= FEED_SPACER;
            if (frame_cnt == LAST) begin
              frame_cnt  <= '0;
              frame_done <= ON;
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
        end
        FEED_SPACER: begin
          if (!ack_s) begin
            if (!fifo_empty) begin
              xt    <= head;
              xf    <= ~head;
              state <= FEED_DATA;
            end else begin
              state <= FEED_IDLE;
            end
          end
        end
        default: begin
          xt    <= {WIDTH{OFF}};
          xf    <= {WIDTH{OFF}};
          state <= FEED_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_layer0_feeder.sv
// Directed bench for layer0_feeder (DEPTH=4, FRAME_LEN=3); ack latency follows LAYER0_FEEDER_ACK_SYNC_EN.
module tb_layer0_feeder;
  import layer0_feeder_pkg::*;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int FL = 3;
`ifdef LAYER0_FEEDER_ACK_SYNC_EN
  localparam int L = 2;
`else
  localparam int L = 0;
`endif

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         ack = 1'b0;
  logic [W-1:0] xt;
  logic [W-1:0] xf;
  logic         frame_done;

  int vectors = 0;
  int miscompares = 0;

  layer0_feeder #(.WIDTH(W), .DEPTH(D), .FRAME_LEN(FL)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .ack(ack), .xt(xt), .xf(xf), .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  // Rail exclusivity must hold on every cycle outside reset.
  always @(negedge clock) begin
    if (reset) begin
      vectors++;
      if ((xt & xf) !== '0) begin
        miscompares++;
        $display("FAIL rail_overlap: xt=%h xf=%h required xt&xf=00", xt, xf);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wait_data(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 60; t++) begin
      if ((xt | xf) !== '0) begin ok = 1'b1; break; end
      step(1);
    end
  endtask

  task automatic wait_spacer(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 60; t++) begin
      if ((xt | xf) === '0) begin ok = 1'b1; break; end
      step(1);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b0; in_valid = 1'b0; ack = 1'b0;
    step(2);
    reset = 1'b1;
    step(1);
  endtask

  task automatic push_words(input logic [W-1:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = first + W'(i);
      for (int t = 0; t < 300 && !in_ready; t++) step(1);
      step(1);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b1; in_data = 8'h5A;
    step(3);
    vectors++;
    if (xt !== 8'h00 || xf !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_rails: xt=%h xf=%h required 00/00", xt, xf);
    end
    vectors++;
    if (frame_done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_frame_done: got %b required 0", frame_done);
    end
    in_valid = 1'b0;
    reset = 1'b1;
    step(1);
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
    step(3);
    vectors++;
    if (xt !== 8'h00 || dut.fifo_empty !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_no_write: xt=%h empty=%b required 00/1", xt, dut.fifo_empty);
    end
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_data = 8'h5A;
    step(1);
    in_valid = 1'b0;
    vectors++;
    if (xt !== 8'h00) begin
      miscompares++;
      $display("FAIL single_early: xt=%h required 00 after write edge", xt);
    end
    step(1);
    vectors++;
    if (xt !== 8'h5A || xf !== 8'hA5) begin
      miscompares++;
      $display("FAIL single_load: xt=%h xf=%h required 5a/a5", xt, xf);
    end
    step(3);
    vectors++;
    if (xt !== 8'h5A || xf !== 8'hA5) begin
      miscompares++;
      $display("FAIL single_stable: xt=%h xf=%h required 5a/a5", xt, xf);
    end
    ack = 1'b1;
    step(L);
    vectors++;
    if (xt !== 8'h5A) begin
      miscompares++;
      $display("FAIL single_ack_early: xt=%h required 5a before sync delay", xt);
    end
    step(1);
    vectors++;
    if (xt !== 8'h00 || xf !== 8'h00) begin
      miscompares++;
      $display("FAIL single_spacer: xt=%h xf=%h required 00/00", xt, xf);
    end
    ack = 1'b0;
    step(L);
    vectors++;
    if (dut.state !== FEED_SPACER) begin
      miscompares++;
      $display("FAIL single_hold_spacer: state=%0d required %0d", dut.state, FEED_SPACER);
    end
    step(1);
    vectors++;
    if (dut.state !== FEED_IDLE || xt !== 8'h00) begin
      miscompares++;
      $display("FAIL single_idle: state=%0d xt=%h required %0d/00", dut.state, xt, FEED_IDLE);
    end
  endtask

  task automatic test_back_pressure();
    int accepted;
    bit ok;
    logic [W-1:0] exp;
    apply_reset();
    accepted = 0;
    in_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      in_data = 8'h11 + W'(accepted);
      if (in_ready) accepted++;
      step(1);
      if (c == 2) begin
        vectors++;
        if (in_ready !== 1'b1) begin
          miscompares++;
          $display("FAIL bp_ready_3: got %b required 1", in_ready);
        end
      end
      if (c == 3) begin
        vectors++;
        if (in_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL bp_ready_full: got %b required 0", in_ready);
        end
      end
    end
    in_valid = 1'b0;
    vectors++;
    if (accepted != 4) begin
      miscompares++;
      $display("FAIL bp_accepted: got %0d required 4", accepted);
    end
    vectors++;
    if (xt !== 8'h11) begin
      miscompares++;
      $display("FAIL bp_head_hold: xt=%h required 11", xt);
    end
    for (int k = 0; k < 4; k++) begin
      exp = 8'h11 + W'(k);
      wait_data(ok);
      vectors++;
      if (!ok || xt !== exp) begin
        miscompares++;
        $display("FAIL bp_drain: xt=%h required %h (ok=%b)", xt, exp, ok);
      end
      ack = 1'b1;
      wait_spacer(ok);
      ack = 1'b0;
    end
    step(L + 3);
    vectors++;
    if (in_ready !== 1'b1 || xt !== 8'h00) begin
      miscompares++;
      $display("FAIL bp_drained: in_ready=%b xt=%h required 1/00", in_ready, xt);
    end
  endtask

  task automatic test_stream_order();
    apply_reset();
    fork
      push_words(8'h01, 8);
      begin
        bit ok;
        logic [W-1:0] exp;
        for (int k = 0; k < 8; k++) begin
          exp = W'(k + 1);
          wait_data(ok);
          vectors++;
          if (!ok || xt !== exp || xf !== ~exp) begin
            miscompares++;
            $display("FAIL stream_word%0d: xt=%h xf=%h required %h/%h", k, xt, xf, exp, ~exp);
          end
          step($urandom_range(5, 2));
          vectors++;
          if (xt !== exp) begin
            miscompares++;
            $display("FAIL stream_stable%0d: xt=%h required %h", k, xt, exp);
          end
          ack = 1'b1;
          wait_spacer(ok);
          vectors++;
          if (!ok) begin
            miscompares++;
            $display("FAIL stream_spacer%0d: xt=%h xf=%h required 00/00", k, xt, xf);
          end
          ack = 1'b0;
        end
      end
    join
  endtask

  task automatic test_frame_wrap();
    apply_reset();
    fork
      push_words(8'h21, 7);
      begin
        bit ok;
        logic want;
        for (int k = 0; k < 7; k++) begin
          wait_data(ok);
          ack = 1'b1;
          wait_spacer(ok);
          want = (k == 2 || k == 5);
          vectors++;
          if (!ok || frame_done !== want) begin
            miscompares++;
            $display("FAIL frame_pulse_ack%0d: got %b required %b (ok=%b)", k + 1, frame_done, want, ok);
          end
          ack = 1'b0;
          step(1);
          vectors++;
          if (frame_done !== 1'b0) begin
            miscompares++;
            $display("FAIL frame_width_ack%0d: got %b required 0", k + 1, frame_done);
          end
        end
      end
    join
    vectors++;
    if (dut.frame_cnt !== 2'd1) begin
      miscompares++;
      $display("FAIL frame_count: got %0d required 1", dut.frame_cnt);
    end
  endtask

  task automatic test_reset_mid_token();
    bit ok;
    apply_reset();
    push_words(8'h31, 3);
    wait_data(ok);
    vectors++;
    if (!ok || xt !== 8'h31) begin
      miscompares++;
      $display("FAIL mid_setup: xt=%h required 31", xt);
    end
    reset = 1'b0;
    step(1);
    vectors++;
    if (xt !== 8'h00 || xf !== 8'h00 || frame_done !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_spacer: xt=%h xf=%h fd=%b required 00/00/0", xt, xf, frame_done);
    end
    vectors++;
    if (dut.fifo_empty !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_fifo_empty: got %b required 1", dut.fifo_empty);
    end
    reset = 1'b1;
    step(4);
    vectors++;
    if (xt !== 8'h00 || frame_done !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_after: xt=%h fd=%b in_ready=%b required 00/0/1", xt, frame_done, in_ready);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    step(1);
    test_reset();
    test_single();
    test_back_pressure();
    test_stream_order();
    test_frame_wrap();
    test_reset_mid_token();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/layer0_feeder.md
# layer0_feeder

Synchronous-to-dual-rail bridge directly upstream of `layer0`. Accepts activation words on a clocked valid/ready port and buffers them in a small FIFO. Presents each word to `layer0` as a four-phase return-to-zero dual-rail token on `xt`/`xf`, paced by `layer0`'s `ack_prev`. Counts acknowledged tokens and flags the end of each input frame.

## Interface
Parameters:
- `WIDTH`, default `` `BIT_INL0 ``: token width; matches `layer0` `xt`/`xf`.
- `DEPTH`, default 4: FIFO entries; power of two, ≥ 2.
- `FRAME_LEN`, default 784: tokens per frame.

Ports:
- `clock`  in  1: single clock; all state on rising edge.
- `reset`  in  1: synchronous, active-low reset.
- `in_valid`  in  1: upstream word valid.
- `in_ready`  out  1: FIFO can accept (`!full`).
- `in_data`  in  WIDTH: signed activation word.
- `ack`  in  1: connects to `layer0.ack_prev`; asynchronous to `clock`.
- `xt`  out  WIDTH: true rail.
- `xf`  out  WIDTH: false rail.
- `frame_done`  out  1: one-cycle pulse when the last token of a frame is acknowledged.

## Operation
- FIFO:
  - Write on `in_valid && in_ready`; pop on the DATA→SPACER transition.
  - Simultaneous write and pop leaves the occupancy count unchanged.
  - Pointers wrap modulo DEPTH; occupancy counter runs 0..DEPTH.
- `ack_s` is the internal view of `ack`; see Configuration.
- FSM (registered state; outputs registered):
  - IDLE: `xt=xf=0`. If FIFO is non-empty and `ack_s==0`, load the FIFO head and go to DATA.
  - DATA: `xt=head`, `xf=~head`, so every bit has exactly one rail high. When `ack_s==1`: pop, drive `xt=xf=0`, go to SPACER.
  - SPACER: `xt=xf=0`. When `ack_s==0`: if the FIFO is non-empty, load the next head and go to DATA; otherwise go to IDLE.
- Rail invariants:
  - Never change `xt`/`xf` while in DATA.
  - Never drive both rails of any bit high.
  - Never drive a new codeword before `ack_s` has returned low.
- Frame counter:
  - Increments on each DATA→SPACER transition.
  - When the counter equals FRAME_LEN−1 at that transition: pulse `frame_done` for one cycle and wrap the counter to 0.

## Timing
- Reset (`reset==0` at an edge) forces:
  - `xt=0`, `xf=0`, `frame_done=0`
  - FSM=IDLE, FIFO empty, frame counter 0, synchronizer flops 0
  - `in_ready=1` from the first cycle after reset is released.
- Reset mid-token drops the codeword to spacer on the next edge and discards FIFO contents. The integrator resets `layer0` in the same window.
- Latency, with the FIFO empty, FSM in IDLE and `ack_s==0`: word accepted at edge N → `xt`/`xf` valid after edge N+2 (FIFO write, then FSM load).
- Ack to spacer:
  - `ack` rising → spacer driven L+1 edges later, where L is the synchronizer depth (2 or 0).
  - The same L+1 applies from `ack` falling to the next codeword.
- `frame_done` asserts on the same edge that drives the spacer for the last token of the frame.
- Full: `in_ready=0` while occupancy == DEPTH. A pop in the same cycle does not raise `in_ready` combinationally; it rises the next cycle.
- Empty in SPACER: go to IDLE. No spurious codeword is driven.

## Configuration
- `LAYER0_FEEDER_ACK_SYNC_EN` defined:
  - `ack` passes through a two-flop synchronizer, reset to 0, before use; `ack_s` is the second flop.
  - Required for silicon.
- Undefined:
  - `ack_s = ack` directly, with zero added latency.
  - For zero-delay simulation only.

## Structure
- `definitions.v` supplies:
  - `` `BIT_INL0 ``, used as the WIDTH default.
  - `` `ON ``/`` `OFF `` for rail constants.
  - New FSM state encodings `` `FEED_IDLE ``, `` `FEED_DATA ``, `` `FEED_SPACER `` (2 bits).
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH; push/pop/full/empty/head) holds the buffer.
- The FSM, frame counter and optional synchronizer live in `layer0_feeder`.

## Test plan
- Reset: hold `reset=0` 3 cycles with `in_valid=1`, `in_data=8'h5A` → `xt=xf=0`, `in_ready=1` after release, no write during reset.
- Single token, sync enabled: push `8'h5A`; `ack` stays 0 → `xt=8'h5A`, `xf=8'hA5` from edge N+2 and stable. Raise `ack` → spacer 3 edges later. Drop `ack` → FSM returns to IDLE.
- Back-pressure: DEPTH=4, `ack` held 0, push 6 words → 4 accepted, `in_ready=0` from the cycle after the 4th write. `xt` holds word 0 until acked.
- Stream order: push 1..8, auto-ack responder with 2–5 cycle random delay → `xt` sequence 1..8. Every codeword is separated by an all-zero spacer; `xt & xf` is always 0.
- Frame wrap: FRAME_LEN=3, stream 7 tokens → `frame_done` pulses on acks 3 and 6 only; the counter reads 1 after ack 7.
- Reset mid-token: assert reset while in DATA with 2 words queued → spacer next edge, FIFO empty, `frame_done` stays 0.
